wb_regfile: RTL and testbench

//  Write-back stage plus architectural register file; consumes the MEM/WB

---
 rtl/wb_regfile.sv | 57 +++++
 tb/tb_wb_regfile.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// Write-back select plus 32-entry architectural register file with two combinational read ports.
// Optional macro WB_BYPASS_EN: read ports return the value being written back in the same cycle.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREG   = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [1:0]        WB_i,
  input  logic [DATA_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [ADDR_W-1:0] rd_i,
  input  logic [ADDR_W-1:0] rs_addr_i,
  input  logic [ADDR_W-1:0] rt_addr_i,
  output logic [DATA_W-1:0] rs_data_o,
  output logic [DATA_W-1:0] rt_data_o,
  output logic [DATA_W-1:0] wb_data_o,
  output logic              wb_we_o
);

  logic [DATA_W-1:0] regs [NREG];

  assign wb_data_o = WB_i[0] ? data_i : addr_i;
  assign wb_we_o   = WB_i[1] && (rd_i != '0);

  // Register 0 is never written because wb_we_o already excludes index 0.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_we_o) begin
      regs[rd_i] <= wb_data_o;
    end
  end

  always_comb begin
    rs_data_o = regs[rs_addr_i];
    rt_data_o = regs[rt_addr_i];
`ifdef WB_BYPASS_EN
    if (wb_we_o && (rs_addr_i == rd_i)) begin
      rs_data_o = wb_data_o;
    end
    if (wb_we_o && (rt_addr_i == rd_i)) begin
      rt_data_o = wb_data_o;
    end
`endif
    if (rs_addr_i == '0) begin
      rs_data_o = '0;
    end
    if (rt_addr_i == '0) begin
      rt_data_o = '0;
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed cases with literal expectations plus
// randomized traffic compared every cycle against an array-based reference model.
`timescale 1ns/10ps
module tb_wb_regfile;

  logic        clk;
  logic        rst_n;
  logic [1:0]  wb;
  logic [31:0] addr;
  logic [31:0] data;
  logic [4:0]  rd;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] wb_data;
  logic        wb_we;

  int pass_cnt  = 0;
  int check_cnt = 0;
  bit run_cmp   = 0;
  bit bypass;

  logic [31:0] model_mem [32];

  wb_regfile dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .WB_i      (wb),
    .addr_i    (addr),
    .data_i    (data),
    .rd_i      (rd),
    .rs_addr_i (rs_addr),
    .rt_addr_i (rt_addr),
    .rs_data_o (rs_data),
    .rt_data_o (rt_data),
    .wb_data_o (wb_data),
    .wb_we_o   (wb_we)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
`ifdef WB_BYPASS_EN
    bypass = 1;
`else
    bypass = 0;
`endif
  end

  function automatic logic [31:0] exp_sel();
    return wb[0] ? data : addr;
  endfunction

  function automatic logic exp_we();
    return wb[1] && (rd != 0);
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (bypass && exp_we() && a == rd) return exp_sel();
    return model_mem[a];
  endfunction

  // Reference register file: cleared while reset is low, otherwise commits on each edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) model_mem[i] = 32'h0;
    end else if (exp_we()) begin
      model_mem[rd] = exp_sel();
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic apply_stimulus(input logic [1:0] w, input logic [31:0] a, input logic [31:0] d,
                                input logic [4:0] r, input logic [4:0] s, input logic [4:0] t);
    @(posedge clk);
    #1;
    wb = w; addr = a; data = d; rd = r; rs_addr = s; rt_addr = t;
  endtask

  // Per-cycle comparison against the model, away from the write edge.
  always @(negedge clk) begin
    if (run_cmp && rst_n) begin
      check_output("cyc_wb_data", wb_data, exp_sel());
      check_output("cyc_wb_we", {31'h0, wb_we}, {31'h0, exp_we()});
      check_output("cyc_rs_data", rs_data, exp_read(rs_addr));
      check_output("cyc_rt_data", rt_data, exp_read(rt_addr));
    end
  end

  initial begin
    rst_n = 0;
    wb = 2'bxx; addr = 0; data = 0; rd = 0; rs_addr = 0; rt_addr = 0;
    repeat (2) @(posedge clk);
    #1;
    wb = 2'b00;
    rst_n = 1;
    #1;
    check_output("post_reset_rs", rs_data, 32'h0);
    run_cmp = 1;

    apply_stimulus(2'b10, 32'h0000_1234, 32'h0, 5'd5, 5'd5, 5'd0);
    #1;
    check_output("alu_wb_data", wb_data, 32'h0000_1234);
    check_output("alu_wb_we", {31'h0, wb_we}, 32'h1);
    apply_stimulus(2'b00, 32'h0, 32'h0, 5'd0, 5'd5, 5'd0);
    #1;
    check_output("alu_reg5", rs_data, 32'h0000_1234);

    apply_stimulus(2'b11, 32'h0000_0010, 32'hDEAD_BEEF, 5'd9, 5'd9, 5'd5);
    #1;
    check_output("load_wb_data", wb_data, 32'hDEAD_BEEF);
    apply_stimulus(2'b00, 32'h0, 32'h0, 5'd0, 5'd9, 5'd5);
    #1;
    check_output("load_reg9", rs_data, 32'hDEAD_BEEF);
    check_output("load_reg5", rt_data, 32'h0000_1234);

    apply_stimulus(2'b10, 32'hFFFF_FFFF, 32'h0, 5'd0, 5'd0, 5'd0);
    #1;
    check_output("r0_we", {31'h0, wb_we}, 32'h0);
    check_output("r0_wb_data", wb_data, 32'hFFFF_FFFF);
    apply_stimulus(2'b00, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    #1;
    check_output("r0_read", rs_data, 32'h0);

    apply_stimulus(2'b10, 32'h0000_0077, 32'h0, 5'd7, 5'd0, 5'd0);
    repeat (3) apply_stimulus(2'b00, 32'h5555_5555, 32'h6666_6666, 5'd7, 5'd7, 5'd7);
    apply_stimulus(2'b00, 32'h0, 32'h0, 5'd0, 5'd7, 5'd7);
    #1;
    check_output("nowrite_reg7", rs_data, 32'h0000_0077);

    apply_stimulus(2'b10, 32'h0000_0001, 32'h0, 5'd3, 5'd0, 5'd0);
    apply_stimulus(2'b10, 32'hAAAA_5555, 32'h0, 5'd3, 5'd3, 5'd3);
    #1;
    check_output("same_cyc_rs", rs_data, bypass ? 32'hAAAA_5555 : 32'h0000_0001);
    check_output("same_cyc_rt", rt_data, bypass ? 32'hAAAA_5555 : 32'h0000_0001);
    apply_stimulus(2'b00, 32'h0, 32'h0, 5'd0, 5'd3, 5'd3);
    #1;
    check_output("after_edge_rs", rs_data, 32'hAAAA_5555);
    check_output("after_edge_rt", rt_data, 32'hAAAA_5555);

    for (int n = 0; n < 300; n++) begin
      logic [4:0] r;
      r = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      apply_stimulus(2'($urandom), $urandom, $urandom, r,
                     ($urandom_range(0, 3) == 0) ? r : 5'($urandom),
                     ($urandom_range(0, 3) == 0) ? r : 5'($urandom));
    end

    // Mid-run asynchronous reset with undefined control; every register must read 0 at once.
    @(posedge clk);
    #1;
    rst_n = 0;
    wb = 2'bxx;
    for (int i = 0; i < 16; i++) begin
      rs_addr = 5'(2 * i);
      rt_addr = 5'(2 * i + 1);
      #0.2;
      check_output("rst_rs", rs_data, 32'h0);
      check_output("rst_rt", rt_data, 32'h0);
    end
    @(posedge clk);
    #1;
    wb = 2'b10; addr = 32'h0BAD_F00D; rd = 5'd12; rs_addr = 5'd12; rt_addr = 5'd0;
    rst_n = 1;
    apply_stimulus(2'b00, 32'h0, 32'h0, 5'd0, 5'd12, 5'd20);
    #1;
    check_output("rst_release_write", rs_data, 32'h0BAD_F00D);
    check_output("rst_release_other", rt_data, 32'h0);

    for (int n = 0; n < 200; n++) begin
      logic [4:0] r;
      r = 5'($urandom);
      apply_stimulus(2'($urandom), $urandom, $urandom, r,
                     ($urandom_range(0, 2) == 0) ? r : 5'($urandom), 5'($urandom));
    end

    @(posedge clk);
    #1;
    run_cmp = 0;
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
